// File: rtl/branch_bht_predictor.sv
// rtl/branch_bht_predictor.sv - 2-bit saturating-counter branch history table with init sweep.
// Optional gshare indexing enabled by defining BHT_GSHARE_EN.
module branch_bht_predictor #(
  parameter int         INDEX_BITS  = 6,
  parameter logic [1:0] RESET_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  pred_req,
  input  logic [31:0]           pred_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_pred,
  output logic                  mispredict
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [1:0]            table_q [ENTRIES];
  logic [1:0]            table_d [ENTRIES];
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [INDEX_BITS-1:0] pred_idx_q, pred_idx_d;
  logic                  mispredict_q, mispredict_d;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [1:0]            upd_cur;
  logic                  upd_accept;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};
  assign upd_accept     = upd_valid && (state_q == ST_RUN);
  assign upd_cur        = table_q[upd_idx];

`ifdef BHT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  // Lookup uses the history as it stood before any same-cycle training.
  assign lookup_idx = pred_pc[INDEX_BITS+1:2] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_accept) ghr_d = {ghr_q[INDEX_BITS-2:0], upd_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign lookup_idx = pred_pc[INDEX_BITS+1:2];
`endif

  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    table_d      = table_q;
    pred_valid_d = 1'b0;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    mispredict_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        table_d[init_ptr_q] = RESET_STATE;
        init_ptr_d          = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) state_d = ST_RUN;
      end
      default: begin
        // Reads table_q, so a same-index update this cycle is not yet visible.
        if (pred_req) begin
          pred_valid_d = 1'b1;
          pred_taken_d = table_q[lookup_idx][1];
          pred_idx_d   = lookup_idx;
        end
        if (upd_valid) begin
          if (upd_taken) table_d[upd_idx] = (upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'd1;
          else           table_d[upd_idx] = (upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'd1;
          mispredict_d = (upd_taken != upd_pred);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Table contents need no reset: the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

  assign ready      = (state_q == ST_RUN);
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;
  assign mispredict = mispredict_q;

endmodule

// File: tb/tb_branch_bht_predictor.sv
// tb/tb_branch_bht_predictor.sv - self-checking bench for branch_bht_predictor.
module tb_branch_bht_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic        pred_req = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred = 1'b0;
  logic        mispredict;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_bht_predictor #(.INDEX_BITS(6), .RESET_STATE(2'b01)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  // Reference model: counters as plain integers, init as a cycle count.
  int m_ctr [64];
  int m_cnt   = 0;
  int m_ghr   = 0;
  bit m_ready = 0;
  bit started = 0;
  int e_valid = 0, e_taken = 0, e_idx = 0, e_mis = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 0; m_cnt = 0; m_ghr = 0;
      e_valid = 0; e_taken = 0; e_idx = 0; e_mis = 0;
    end else begin
      bit was_ready;
      int idx;
      was_ready = m_ready;
      e_valid = 0;
      e_mis   = 0;
      if (was_ready && pred_req) begin
        idx = ((int'(pred_pc) / 4) % 64) ^ m_ghr;
        e_valid = 1;
        e_taken = (m_ctr[idx] >= 2) ? 1 : 0;
        e_idx   = idx;
      end
      if (was_ready && upd_valid) begin
        if (upd_taken) m_ctr[upd_idx] = (m_ctr[upd_idx] + 1 > 3) ? 3 : m_ctr[upd_idx] + 1;
        else           m_ctr[upd_idx] = (m_ctr[upd_idx] - 1 < 0) ? 0 : m_ctr[upd_idx] - 1;
        e_mis = (upd_taken != upd_pred) ? 1 : 0;
`ifdef BHT_GSHARE_EN
        m_ghr = (m_ghr * 2 + int'(upd_taken)) % 64;
`endif
      end
      if (!was_ready) begin
        m_cnt++;
        if (m_cnt == 64) begin
          m_ready = 1;
          for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        end
      end
    end
    started = 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("ready", int'(ready), int'(m_ready));
      check("pred_valid", int'(pred_valid), e_valid);
      check("pred_taken", int'(pred_taken), e_taken);
      check("pred_idx", int'(pred_idx), e_idx);
      check("mispredict", int'(mispredict), e_mis);
    end
  end

  task automatic step(input logic req, input logic [31:0] pc, input logic uv,
                      input logic [5:0] ui, input logic ut, input logic up);
    pred_req = req; pred_pc = pc; upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
    @(negedge clk);
    pred_req = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic count_init(input string name);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 64);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    count_init("init_cycles");

    step(1, 32'h60, 0, 0, 0, 0);
    check("lit_0x60_valid", int'(pred_valid), 1);
    check("lit_0x60_taken", int'(pred_taken), 0);
    check("lit_0x60_idx", int'(pred_idx), 24);

    step(0, 0, 1, 6'd5, 1, 0);
    check("lit_mis_set", int'(mispredict), 1);
    step(0, 0, 0, 0, 0, 0);
    check("lit_mis_clear", int'(mispredict), 0);
    step(0, 0, 1, 6'd5, 1, 1);
    check("lit_mis_agree", int'(mispredict), 0);
    step(1, 32'h14, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    check("lit_ctr11_taken", int'(pred_taken), 1);
`endif
    step(0, 0, 1, 6'd5, 1, 1);
    step(1, 32'h14, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    check("lit_sat_hi", int'(pred_taken), 1);
`endif
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'd5, 0, 1);
    step(1, 32'h14, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    check("lit_ctr00_taken", int'(pred_taken), 0);
`endif
    step(0, 0, 1, 6'd5, 0, 0);
    step(0, 0, 1, 6'd5, 1, 0);
    step(1, 32'h14, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    check("lit_sat_lo", int'(pred_taken), 0);
`endif

    step(1, 32'h0C, 1, 6'd3, 1, 0);
`ifndef BHT_GSHARE_EN
    check("lit_rbw_old", int'(pred_taken), 0);
`endif
    step(1, 32'h0C, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    check("lit_rbw_new", int'(pred_taken), 1);
`endif

    // Restart INIT when the sweep pointer reaches 20; traffic during INIT is ignored.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h14, 1, 6'd5, 1, 0);
      check("lit_init_no_pred", int'(pred_valid), 0);
    end
    do_reset();
    count_init("reinit_cycles");

    step(0, 0, 1, 6'd9, 1, 1);
    step(0, 0, 1, 6'd9, 1, 1);
    step(1, 32'h14, 0, 0, 0, 0);
`ifdef BHT_GSHARE_EN
    check("lit_gshare_idx", int'(pred_idx), 6);
`else
    check("lit_plain_idx", int'(pred_idx), 5);
`endif
    check("lit_reinit_taken", int'(pred_taken), 0);

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), $urandom & 32'h0000_003F, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
